// File: rtl/gemm_result_drain_pkg.sv
// Shared types and the int32 -> int8 requantizer for the GEMM result drain.
package gemm_result_drain_pkg;

    localparam int unsigned PREC_INT8  = 0;
    localparam int unsigned PREC_INT32 = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } drain_state_e;

    // Round-half-up arithmetic shift in 33 bits, then clamp to int8.
    function automatic logic [7:0] requant_i8(input logic [31:0] acc, input logic [4:0] sh,
                                              output logic sat_flag);
        logic signed [32:0] rnd;
        logic signed [32:0] s;
        logic signed [32:0] y;
        rnd      = (sh != 5'd0) ? (33'sd1 <<< (sh - 5'd1)) : 33'sd0;
        s        = $signed({acc[31], acc}) + rnd;
        y        = s >>> sh;
        sat_flag = 1'b0;
        if (y > 33'sd127) begin
            sat_flag = 1'b1;
            return 8'h7F;
        end
        if (y < -33'sd128) begin
            sat_flag = 1'b1;
            return 8'h80;
        end
        return y[7:0];
    endfunction

endpackage

// File: rtl/gemm_result_drain_fifo.sv
// Synchronous FIFO holding {last, data} output words.
module gemm_result_drain_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/gemm_result_drain.sv
// Drains int32 GEMM results from the C BRAM, requantizes to int8, packs 4/word and streams them out.
module gemm_result_drain
    import gemm_result_drain_pkg::*;
#(
    parameter int unsigned MAX_ELEMS  = 16384,
    parameter int unsigned PREC       = PREC_INT8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [15:0]                  M,
    input  logic [15:0]                  Ncols,
    input  logic [4:0]                   shift,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(MAX_ELEMS)-1:0] addr_C,
    input  logic [31:0]                  data_C,
    output logic [31:0]                  out_data,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  sat_count
);
    localparam int unsigned AW      = $clog2(MAX_ELEMS);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam bit          IS_INT8 = (PREC == PREC_INT8);

    drain_state_e  state, state_next;
    logic          busy_d, done_d;
    logic [31:0]   start_total, total, iss_cnt;
    logic [4:0]    shift_q;
    logic [1:0]    iss_lane, pk_lane;
    logic          issue, word_start, iss_last, credit_ok;
    logic          rd_valid, rd_last, rq_valid, rq_last;
    logic [31:0]   rq_data, pk_word, pk_merged;
    logic [7:0]    rq_byte;
    logic          rq_sat;
    logic          push, pop, fifo_full, fifo_empty;
    logic [32:0]   push_data, pop_data;
    logic [CW-1:0] fifo_count, open_words;

    assign start_total = 32'(M) * 32'(Ncols);

    // State register with registered FSM outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = (start_total == 32'd0) ? S_DONE : S_RUN;
            S_RUN:   if (issue && iss_last) state_next = S_FLUSH;
            S_FLUSH: if (!rd_valid && open_words == '0 && fifo_empty) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_next == S_RUN || state_next == S_FLUSH) busy_d = 1'b1;
        if (state_next == S_DONE) done_d = 1'b1;
    end

    // A read that opens a new output word must reserve a FIFO slot for it.
    always_comb begin
        word_start = !IS_INT8 || (iss_lane == 2'd0);
        credit_ok  = ({1'b0, fifo_count} + {1'b0, open_words}) < (CW + 1)'(FIFO_DEPTH);
        issue      = (state == S_RUN) && (!word_start || credit_ok);
        iss_last   = (iss_cnt == total - 32'd1);
    end

    always_comb begin
        rq_sat  = 1'b0;
        rq_byte = requant_i8(data_C, shift_q, rq_sat);
    end

    always_comb begin
        pk_merged = pk_word | (32'(rq_data[7:0]) << {pk_lane, 3'b000});
        push      = rq_valid && (!IS_INT8 || pk_lane == 2'd3 || rq_last);
        push_data = {rq_last, IS_INT8 ? pk_merged : rq_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_C     <= '0;
            iss_cnt    <= '0;
            iss_lane   <= '0;
            total      <= '0;
            shift_q    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rq_valid   <= 1'b0;
            rq_last    <= 1'b0;
            rq_data    <= '0;
            pk_lane    <= '0;
            pk_word    <= '0;
            open_words <= '0;
            sat_count  <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                total     <= start_total;
                shift_q   <= shift;
                addr_C    <= '0;
                iss_cnt   <= '0;
                iss_lane  <= '0;
                sat_count <= '0;
            end else if (issue) begin
                iss_cnt  <= iss_cnt + 32'd1;
                iss_lane <= iss_lane + 2'd1;
                if (!iss_last) addr_C <= addr_C + AW'(1);
            end
            rd_valid <= issue;
            rd_last  <= issue && iss_last;
            rq_valid <= rd_valid;
            rq_last  <= rd_last;
            if (rd_valid) begin
                rq_data <= IS_INT8 ? {24'd0, rq_byte} : data_C;
                if (IS_INT8 && rq_sat && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
            end
            if (push) begin
                pk_word <= '0;
                pk_lane <= '0;
            end else if (rq_valid) begin
                pk_word <= pk_merged;
                pk_lane <= pk_lane + 2'd1;
            end
            case ({issue && word_start, push})
                2'b10:   open_words <= open_words + CW'(1);
                2'b01:   open_words <= open_words - CW'(1);
                default: open_words <= open_words;
            endcase
        end
    end

    gemm_result_drain_fifo #(
        .WIDTH(33),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(push_data),
        .pop  (pop),
        .rdata(pop_data),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_last  = pop_data[32];
    assign out_data  = pop_data[31:0];

    a_push_room:  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
    a_addr_range: assert property (@(posedge clk) disable iff (rst) issue |-> (32'(addr_C) < total));
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
                                   (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_gemm_result_drain.sv
// Randomized self-checking bench for gemm_result_drain against a behavioural requant/pack model.
module tb_gemm_result_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] M, Ncols;
    logic [4:0]  shift;
    logic        busy, done;
    logic [13:0] addr_C;
    logic [31:0] data_C;
    logic [31:0] out_data;
    logic        out_last, out_valid, out_ready;
    logic [15:0] sat_count;

    int          cmem [256];
    logic [32:0] exp_q [$];
    int          exp_sat;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    int          accepted = 0;
    int          cycle = 0;
    int          stall_until = 0;
    bit          ready_rand = 1'b0;

    gemm_result_drain dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .M        (M),
        .Ncols    (Ncols),
        .shift    (shift),
        .busy     (busy),
        .done     (done),
        .addr_C   (addr_C),
        .data_C   (data_C),
        .out_data (out_data),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM model.
    always @(posedge clk) data_C <= cmem[addr_C[7:0]];

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #1;
        if (cycle < stall_until) out_ready = 1'b0;
        else if (ready_rand)     out_ready = 1'($urandom_range(0, 1));
        else                     out_ready = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] ref_rq(input int acc, input int sh, inout int sat);
        longint y;
        y = longint'(acc);
        if (sh > 0) y = y + (longint'(1) << (sh - 1));
        y = y >>> sh;
        if (y > 127)  begin sat++; return 8'h7F; end
        if (y < -128) begin sat++; return 8'h80; end
        return 8'(y);
    endfunction

    task automatic build_model(input int total, input int sh);
        logic [31:0] w;
        exp_q.delete();
        exp_sat = 0;
        for (int base = 0; base < total; base += 4) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++)
                if (base + k < total) w = w | (32'(ref_rq(cmem[base + k], sh, exp_sat)) << (8 * k));
            exp_q.push_back({(base + 4 >= total), w});
        end
    endtask

    function automatic int rand_elem();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    // Output scoreboard and stall-stability checks.
    logic        stall_pend = 1'b0;
    logic [32:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_word", 64'({out_last, out_data}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'({out_last, out_data}), 64'hDEAD_0000_0000);
                end else begin
                    check("out_word", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
                    accepted++;
                end
            end
            stall_pend = out_valid && !out_ready;
            held       = {out_last, out_data};
        end
    end

    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            check("done_one_cycle", 64'(done_prev), 64'd0);
        end
        done_prev = done && !rst;
    end

    task automatic pulse_start(input int m, input int n, input int sh);
        @(posedge clk); #1;
        M = 16'(m); Ncols = 16'(n); shift = 5'(sh); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            if (done_cnt != d0) return;
            @(negedge clk); #1;
        end
        if (done_cnt == d0) check({name, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_case(input int m, input int n, input int sh, input int stall, input bit rnd,
                            input int limit, input string name);
        int d0;
        d0          = done_cnt;
        ready_rand  = rnd;
        stall_until = cycle + stall;
        pulse_start(m, n, sh);
        wait_done(d0, limit, name);
        check({name, "_all_words"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy_low"}, 64'(busy), 64'd0);
        check({name, "_sat"}, 64'(sat_count), 64'(exp_sat));
    endtask

    initial begin
        #300000;
        check("global_timeout", 64'd0, 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int d0;
        int m, n, sh;
        rst = 1'b1; start = 1'b0; M = '0; Ncols = '0; shift = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sat", 64'(sat_count), 64'd0);
        check("rst_addr", 64'(addr_C), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Two saturations in one full word.
        cmem[0] = 100; cmem[1] = -200; cmem[2] = 300; cmem[3] = 5;
        build_model(4, 0);
        check("model_t1_word", 64'(exp_q[0]), 64'h1_057F8064);
        check("model_t1_sat", 64'(exp_sat), 64'd2);
        run_case(2, 2, 0, 0, 1'b0, 100, "t1");

        // Rounding shift and a zero-padded partial last word.
        cmem[0] = 24; cmem[1] = -24; cmem[2] = 8; cmem[3] = -8; cmem[4] = 7;
        build_model(5, 4);
        check("model_t2_w0", 64'(exp_q[0]), 64'h0_0001FF02);
        check("model_t2_w1", 64'(exp_q[1]), 64'h1_00000000);
        run_case(1, 5, 4, 0, 1'b0, 100, "t2");

        // Long initial stall, then random backpressure.
        for (int i = 0; i < 16; i++) cmem[i] = rand_elem();
        build_model(16, 6);
        run_case(4, 4, 6, 20, 1'b1, 400, "t3");

        // Empty matrices.
        build_model(0, 0);
        run_case(0, 5, 0, 0, 1'b0, 3, "t4a");
        run_case(3, 0, 0, 0, 1'b0, 3, "t4b");

        // Reset part-way through, then a clean rerun.
        for (int i = 0; i < 16; i++) cmem[i] = rand_elem();
        build_model(16, 3);
        ready_rand = 1'b0;
        d0 = accepted;
        pulse_start(4, 4, 3);
        for (int i = 0; i < 200 && accepted < d0 + 2; i++) @(negedge clk);
        check("t5_two_words", 64'(accepted - d0), 64'd2);
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_valid_after_rst", 64'(out_valid), 64'd0);
        check("t5_busy_after_rst", 64'(busy), 64'd0);
        build_model(16, 3);
        run_case(4, 4, 3, 0, 1'b0, 300, "t5");

        // A second start while busy must be ignored.
        for (int i = 0; i < 16; i++) cmem[i] = rand_elem();
        build_model(16, 5);
        d0 = done_cnt;
        ready_rand = 1'b1;
        pulse_start(4, 4, 5);
        repeat (5) @(posedge clk);
        pulse_start(2, 2, 9);
        wait_done(d0, 400, "t6");
        check("t6_all_words", 64'(exp_q.size()), 64'd0);
        check("t6_sat", 64'(sat_count), 64'(exp_sat));
        repeat (6) @(negedge clk);
        check("t6_single_run", 64'(done_cnt - d0), 64'd1);

        // Random sizes, shifts and backpressure.
        for (int r = 0; r < 8; r++) begin
            m  = int'($urandom_range(1, 6));
            n  = int'($urandom_range(1, 6));
            sh = (r == 7) ? 31 : int'($urandom_range(0, 12));
            for (int i = 0; i < m * n; i++) cmem[i] = rand_elem();
            build_model(m * n, sh);
            run_case(m, n, sh, int'($urandom_range(0, 8)), 1'b1, 1000, "rnd");
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
